led_pattern_engine: RTL

- Parametrised successor to the fixed 16-LED sine/up-down controller.
- Generates one of four LED bar patterns: centre bounce, up/down level, single-dot scanner, off.
- Patterns advance on a divided step tick; LED width and step period are parameters.
- Adds global PWM brightness, saturating up/down level, and a step strobe. Sits between the synchronised board inputs and the LED pins.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_tick_gen.sv | 28 ++
 rtl/led_pattern_engine.sv | 117 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern engine family.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_UPDOWN = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [1:0] UD_INCR = 2'b01;
  localparam logic [1:0] UD_DECR = 2'b10;

endpackage

// File: rtl/led_tick_gen.sv
// Divides i_clk down to a one-cycle tick every TICK_PERIOD cycles; i_clear restarts the period.
module led_tick_gen #(
  parameter int TICK_PERIOD = 6250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] cnt_q;

  assign o_tick = (cnt_q == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clear || o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED bar pattern generator: bounce / up-down level / scanner / off, stepped on a divided
// tick, with global PWM brightness applied to the registered LED outputs.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int N_LEDS      = 16,
  parameter int TICK_PERIOD = 6250000,
  parameter int PWM_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_ud_cmd,
  input  logic [PWM_W-1:0]  i_brightness,
  output logic [N_LEDS-1:0] o_leds,
  output logic              o_step
);

  localparam int H  = N_LEDS / 2;
  localparam int PW = $clog2(N_LEDS);
  localparam int LW = $clog2(N_LEDS + 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(N_LEDS - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(N_LEDS);

  mode_e             mode_q;
  dir_e              dir_q;
  logic [PW-1:0]     pos_q;
  logic [LW-1:0]     level_q;
  logic [PWM_W-1:0]  pwm_q;
  logic              step_q;
  logic [N_LEDS-1:0] leds_q;
  logic [N_LEDS-1:0] pattern;
  logic              tick;
  logic              pwm_en;
  mode_e             mode_in;
  logic              mode_chg;

  assign mode_in  = mode_e'(i_mode);
  assign mode_chg = (mode_in != mode_q);
  assign pwm_en   = (pwm_q < i_brightness) || (&i_brightness);
  assign o_leds   = leds_q;
  assign o_step   = step_q;

  led_tick_gen #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(mode_chg),
    .o_tick (tick)
  );

  always_comb begin
    pattern = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (int'(pos_q) < H) pattern[i] = (i <= H - 1) && (i >= int'(pos_q));
          else                 pattern[i] = (i >= H) && (i <= int'(pos_q));
        end
        MODE_UPDOWN: pattern[i] = (i >= N_LEDS - int'(level_q));
        MODE_SCAN:   pattern[i] = (i == int'(pos_q));
        default:     pattern[i] = 1'b0;
      endcase
    end
  end

  // A mode change wins over a coincident tick: the new pattern always starts from a clean step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q  <= MODE_BOUNCE;
      dir_q   <= DIR_UP;
      pos_q   <= '0;
      level_q <= '0;
      pwm_q   <= '0;
      step_q  <= 1'b0;
      leds_q  <= '0;
    end else begin
      pwm_q  <= pwm_q + PWM_W'(1);
      leds_q <= pattern & {N_LEDS{pwm_en}};
      step_q <= 1'b0;
      if (mode_chg) begin
        mode_q <= mode_in;
        pos_q  <= '0;
        dir_q  <= DIR_UP;
      end else if (tick) begin
        case (mode_q)
          MODE_BOUNCE, MODE_SCAN: begin
            step_q <= 1'b1;
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                pos_q <= POS_LAST - PW'(1);
                dir_q <= DIR_DOWN;
              end else begin
                pos_q <= pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_q <= PW'(1);
                dir_q <= DIR_UP;
              end else begin
                pos_q <= pos_q - PW'(1);
              end
            end
          end
          MODE_UPDOWN: begin
            step_q <= 1'b1;
            if (i_ud_cmd == UD_INCR && level_q != LEVEL_MAX) level_q <= level_q + LW'(1);
            else if (i_ud_cmd == UD_DECR && level_q != '0)   level_q <= level_q - LW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
